ldst_mmio_bridge: RTL

- Parametrised load/store interconnect between the CPU read/write port and the rest of the system.
- Decodes each load/store address to one of three targets:
  - the 32-bit RAM data port (p1);
  - a bank of NUM_OUT memory-mapped output registers (LEDs, etc.);
  - a read-only input register fed by switches, plus a free-running cycle timer.
- Read latency is one cycle for every target, so the CPU sees uniform timing.
- Replaces hard-wired SW/LEDR hookup in the top level.

---
 rtl/ldst_mmio_bridge.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ldst_mmio_bridge.sv
// Load/store interconnect: decodes CPU accesses to RAM, MMIO output registers,
// a synchronised switch input and a free-running timer, with uniform 1-cycle read latency.
module ldst_mmio_bridge #(
    parameter int          MEM_WORDS = 8192,
    parameter logic [31:0] MMIO_BASE = 32'h0000_A000,
    parameter int          NUM_OUT   = 2,
    parameter int          OUT_W     = 8,
    parameter int          IN_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  i_ldst_addr,
    input  logic                         i_ldst_rd,
    input  logic                         i_ldst_wr,
    input  logic [31:0]                  i_ldst_wrdata,
    input  logic [3:0]                   i_ldst_byte_en,
    output logic [31:0]                  o_ldst_rddata,
    output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
    output logic                         o_mem_read,
    output logic                         o_mem_write,
    output logic [31:0]                  o_mem_writedata,
    output logic [3:0]                   o_mem_byteenable,
    input  logic [31:0]                  i_mem_readdata,
    input  logic [IN_W-1:0]              i_sw,
    output logic [NUM_OUT*OUT_W-1:0]     o_out,
    output logic                         o_bus_err
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_END  = 33'(MEM_WORDS) << 2;
    localparam logic [32:0] MMIO_LO  = {1'b0, MMIO_BASE};
    localparam logic [32:0] MMIO_END = MMIO_LO + 33'd256;
    localparam logic [5:0]  IDX_IN   = 6'd0;
    localparam logic [5:0]  IDX_TMR  = 6'd16;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } sel_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    logic [OUT_W-1:0] out_r [NUM_OUT];
    logic [IN_W-1:0]  sync1_r;
    logic [IN_W-1:0]  sync2_r;
    logic [31:0]      timer_r;
    logic [31:0]      mmio_val_r;
    sel_t             sel_r;
    logic             err_r;

    logic [32:0] addr_ext_s;
    logic [31:0] mmio_off_s;
    logic [5:0]  word_idx_s;
    logic        ram_hit_s;
    logic        mmio_hit_s;
    logic        is_in_s;
    logic        is_out_s;
    logic        is_timer_s;
    logic        rd_ok_s;
    logic        err_s;
    logic [31:0] mmio_rd_val_s;

    assign addr_ext_s = {1'b0, i_ldst_addr};
    assign mmio_off_s = i_ldst_addr - MMIO_BASE;
    assign word_idx_s = mmio_off_s[7:2];
    assign ram_hit_s  = addr_ext_s < RAM_END;
    assign mmio_hit_s = (addr_ext_s >= MMIO_LO) && (addr_ext_s < MMIO_END);
    assign is_in_s    = mmio_hit_s && (word_idx_s == IDX_IN);
    assign is_timer_s = mmio_hit_s && (word_idx_s == IDX_TMR);
    assign is_out_s   = mmio_hit_s && (word_idx_s >= 6'd1) && (word_idx_s <= 6'(NUM_OUT));
    // A simultaneous rd+wr is illegal: the write proceeds, the read is squashed.
    assign rd_ok_s    = i_ldst_rd && !i_ldst_wr;

    assign o_mem_addr       = i_ldst_addr[AW+1:2];
    assign o_mem_read       = rd_ok_s && ram_hit_s;
    assign o_mem_write      = i_ldst_wr && ram_hit_s;
    assign o_mem_writedata  = i_ldst_wrdata;
    assign o_mem_byteenable = i_ldst_byte_en;
    assign o_bus_err        = err_r;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign o_out[g*OUT_W +: OUT_W] = out_r[g];
    end

    // MMIO read mux and bus-error detection
    always_comb begin
        mmio_rd_val_s = 32'd0;
        if (is_in_s) begin
            mmio_rd_val_s = 32'(sync2_r);
        end else if (is_timer_s) begin
            mmio_rd_val_s = timer_r;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (is_out_s && (word_idx_s == 6'(k + 1))) begin
                    mmio_rd_val_s = 32'(out_r[k]);
                end
            end
        end
        err_s = 1'b0;
        if (i_ldst_rd && i_ldst_wr) begin
            err_s = 1'b1;
        end else if (i_ldst_wr && !(ram_hit_s || is_out_s || is_timer_s)) begin
            err_s = 1'b1;
        end else if (i_ldst_rd && !(ram_hit_s || is_in_s || is_out_s || is_timer_s)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Load data return: RAM data arrives this cycle, MMIO value was captured on the rd cycle
    always_comb begin
        case (sel_r)
            SEL_RAM:  o_ldst_rddata = i_mem_readdata;
            SEL_MMIO: o_ldst_rddata = mmio_val_r;
            default:  o_ldst_rddata = 32'd0;
        endcase
    end

    // Two-flop synchroniser for the switch inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= i_sw;
            sync2_r <= sync1_r;
        end
    end

    // Free-running timer, loadable by a byte-merged store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= 32'd0;
        end else if (i_ldst_wr && is_timer_s) begin
            timer_r <= byte_merge(timer_r, i_ldst_wrdata, i_ldst_byte_en);
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Output register bank with byte-lane merge; lanes above OUT_W are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (i_ldst_wr && is_out_s && (word_idx_s == 6'(k + 1))) begin
                    out_r[k] <= OUT_W'(byte_merge(32'(out_r[k]), i_ldst_wrdata, i_ldst_byte_en));
                end
            end
        end
    end

    // Read target select and captured MMIO value for next-cycle return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_r      <= SEL_NONE;
            mmio_val_r <= 32'd0;
        end else if (rd_ok_s) begin
            mmio_val_r <= mmio_rd_val_s;
            if (ram_hit_s) begin
                sel_r <= SEL_RAM;
            end else if (is_in_s || is_out_s || is_timer_s) begin
                sel_r <= SEL_MMIO;
            end else begin
                sel_r <= SEL_NONE;
            end
        end else begin
            sel_r <= SEL_NONE;
        end
    end

    // Sticky bus error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule
